// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Covers the bus widths, the access FSM states and the master indices.
package mem_bus_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  // Command latched from the winning master when its grant issues.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker. The grant is combinational from req.
// The last-grant pointer is registered and moves only on advance.
module arb_rr2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last
);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == M_CPU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Reset to "loader went last" so the cpu wins the first contended grant.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= M_LDR;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between cpu (m0) and loader (m1).
// Each access runs SETUP -> STROBE x ACCESS_CYCLES -> HOLD, then one IDLE turnaround cycle.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  state_t           state, state_nxt;
  cmd_t             cmd;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       req;
  logic [1:0]       grant;
  logic             owner;
  logic             issue;
  logic             last_strobe;

  assign req   = {m1_req, m0_req};
  assign issue = (state == IDLE) && (req != 2'b00);

  // The pointer advances on the grant edge, so it names the current owner for the whole access.
  arb_rr2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (issue),
    .grant   (grant),
    .last    (owner)
  );

  assign last_strobe = (state == STROBE) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req != 2'b00) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt == '0) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cmd      <= '0;
      cnt      <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        cmd <= grant[1] ? cmd_t'{m1_we, m1_addr, m1_wdata}
                        : cmd_t'{m0_we, m0_addr, m0_wdata};
      end
      if (state == SETUP) begin
        cnt <= CNT_W'(ACCESS_CYCLES - 1);
      end else if ((state == STROBE) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      // Only the owning master's read register moves; the other one stays put.
      if (last_strobe && !cmd.we) begin
        if (owner == M_LDR) m1_rdata <= mem_rdata;
        else                m0_rdata <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign m0_gnt    = busy && (owner == M_CPU);
  assign m1_gnt    = busy && (owner == M_LDR);
  assign m0_done   = (state == HOLD) && (owner == M_CPU);
  assign m1_done   = (state == HOLD) && (owner == M_LDR);
  assign mem_rd    = (state == STROBE) && !cmd.we;
  assign mem_wr    = (state == STROBE) && cmd.we;
  assign mem_oe    = busy && cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic.
// Traffic is scored against a transaction-level model; two extra instances sweep ACCESS_CYCLES.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr, mem_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic              m0_gnt, m0_done, m1_gnt, m1_done, mem_rd, mem_wr, mem_oe, busy;

  mem_bus_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_oe(mem_oe), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Sweep instances: index 0 has ACCESS_CYCLES=1, index 1 has ACCESS_CYCLES=5; only m0 is used.
  logic              sw_req   [2];
  logic [DATA_W-1:0] sw_mrd   [2];
  logic              sw_rd    [2];
  logic              sw_done  [2];
  logic [DATA_W-1:0] sw_rdata [2];
  logic              sw_g0 [2], sw_g1 [2], sw_d1 [2], sw_wr [2], sw_oe [2], sw_busy [2];
  logic [DATA_W-1:0] sw_r1 [2], sw_wd [2];
  logic [ADDR_W-1:0] sw_addr [2];

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    mem_bus_arbiter #(.ACCESS_CYCLES(g == 0 ? 1 : 5)) u_sw (
      .clk(clk), .reset(reset),
      .m0_req(sw_req[g]), .m0_we(1'b0), .m0_addr(13'h0042), .m0_wdata(8'h00),
      .m0_gnt(sw_g0[g]), .m0_done(sw_done[g]), .m0_rdata(sw_rdata[g]),
      .m1_req(1'b0), .m1_we(1'b0), .m1_addr(13'h0000), .m1_wdata(8'h00),
      .m1_gnt(sw_g1[g]), .m1_done(sw_d1[g]), .m1_rdata(sw_r1[g]),
      .mem_addr(sw_addr[g]), .mem_rd(sw_rd[g]), .mem_wr(sw_wr[g]), .mem_wdata(sw_wd[g]),
      .mem_oe(sw_oe[g]), .mem_rdata(sw_mrd[g]), .busy(sw_busy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: t counts cycles into the current access (0 = bus free).
  // Cycle 1 is address setup, 2..AC+1 carry the strobe, AC+2 is the done cycle.
  int                t;
  logic              m_owner, m_we, m_last;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata [2];

  task automatic model_update();
    if (reset) begin
      t = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (t == 0) begin
      if (m0_req || m1_req) begin
        m_owner = (m0_req && m1_req) ? !m_last : m1_req;
        m_last  = m_owner;
        m_we    = m_owner ? m1_we    : m0_we;
        m_addr  = m_owner ? m1_addr  : m0_addr;
        m_wdata = m_owner ? m1_wdata : m0_wdata;
        t = 1;
      end
    end else if (t == AC + 2) begin
      t = 0;
    end else begin
      if (t == AC + 1 && !m_we) m_rdata[m_owner] = mem_rdata;
      t++;
    end
  endtask

  task automatic compare_all();
    logic [1:0] who;
    logic       strobe;
    who    = m_owner ? 2'b10 : 2'b01;
    strobe = (t >= 2) && (t <= AC + 1);
    check("gnt",    {m1_gnt, m0_gnt},   (t != 0) ? who : 2'b00);
    check("done",   {m1_done, m0_done}, (t == AC + 2) ? who : 2'b00);
    check("ctl",    {busy, mem_oe, mem_wr, mem_rd},
          {t != 0, (t != 0) && m_we, strobe && m_we, strobe && !m_we});
    check("addr",   mem_addr,  m_addr);
    check("wdata",  mem_wdata, m_wdata);
    check("rdata0", m0_rdata,  m_rdata[0]);
    check("rdata1", m1_rdata,  m_rdata[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet();
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic drain();
    quiet();
    for (int i = 0; i < 20 && busy; i++) step();
    check("drain_idle", busy, 1'b0);
  endtask

  int n, n_rd, n_wr, n_oe, n_done, last_done, gaps_ok;
  logic [1:0] order [4];

  initial begin
    reset = 1'b1;
    m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    for (int g = 0; g < 2; g++) begin sw_req[g] = 1'b0; sw_mrd[g] = '0; end

    // Reset with both requests high: everything stays low.
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    step(); step();
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    check("first_gnt", {m1_gnt, m0_gnt}, 2'b01);
    drain();

    // Single m0 read of 0x0005 returning 0xA5.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h0005; mem_rdata = 8'hA5;
    n = 0; n_rd = 0;
    while (n < 12 && !m0_done) begin step(); n++; if (mem_rd) n_rd++; end
    check("rd_latency", n, AC + 2);
    check("rd_width", n_rd, AC);
    check("rd_data", m0_rdata, 8'hA5);
    drain();

    // m1 write 0x1802 <= 0x3C.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 13'h1802; m1_wdata = 8'h3C;
    n = 0; n_wr = 0; n_oe = 0;
    while (n < 12 && !m1_done) begin
      step(); n++;
      if (mem_wr) n_wr++;
      if (mem_oe) n_oe++;
    end
    check("wr_width", n_wr, AC);
    check("wr_oe_span", n_oe, AC + 2);
    check("wr_addr", mem_addr, 13'h1802);
    drain();

    // Contention from reset: grants alternate m0, m1, m0, m1 with a fixed HOLD-to-HOLD gap.
    reset = 1'b1; step(); reset = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    n_done = 0; last_done = -1; gaps_ok = 1;
    for (int c = 0; c < 8 * (AC + 3) && n_done < 4; c++) begin
      step();
      if (m0_done || m1_done) begin
        order[n_done] = {m1_done, m0_done};
        if (last_done >= 0 && c - last_done != AC + 3) gaps_ok = 0;
        last_done = c;
        n_done++;
      end
    end
    check("cont_count", n_done, 4);
    check("cont_order", {order[0], order[1], order[2], order[3]}, 8'b01_10_01_10);
    check("cont_gap", gaps_ok, 1);
    drain();

    // m0 drops req mid-strobe: the access still completes with one done pulse.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h0777; mem_rdata = 8'h5A;
    step(); step();
    check("mid_in_strobe", mem_rd, 1'b1);
    m0_req = 1'b0;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin step(); if (m0_done) n_done++; end
    check("mid_done_once", n_done, 1);
    check("mid_rdata", m0_rdata, 8'h5A);

    // Reset during strobe: strobe drops on that edge and no done follows.
    m0_req = 1'b1; m0_addr = 13'h0123;
    step(); step();
    check("rst_mid_strobe", mem_rd, 1'b1);
    reset = 1'b1; m0_req = 1'b0;
    step();
    check("rst_mid_rd", {busy, mem_rd}, 2'b00);
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin step(); if (m0_done || m1_done) n_done++; end
    check("rst_mid_nodone", n_done, 0);

    // Randomized traffic with occasional resets, scored every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      m0_req    = ($urandom_range(0, 9) < 6);
      m1_req    = ($urandom_range(0, 9) < 6);
      m0_we     = $urandom_range(0, 1) == 1;
      m1_we     = $urandom_range(0, 1) == 1;
      m0_addr   = ADDR_W'($urandom);
      m1_addr   = ADDR_W'($urandom);
      m0_wdata  = DATA_W'($urandom);
      m1_wdata  = DATA_W'($urandom);
      mem_rdata = DATA_W'($urandom);
      step();
    end
    reset = 1'b0;
    drain();

    // ACCESS_CYCLES sweep: strobe width and capture on the final strobe cycle only.
    for (int g = 0; g < 2; g++) begin
      logic [DATA_W-1:0] last_val;
      int exp_ac, seen;
      exp_ac = (g == 0) ? 1 : 5;
      n_rd = 0; seen = 0; last_val = '0;
      sw_mrd[g] = DATA_W'($urandom);
      sw_req[g] = 1'b1;
      for (int c = 0; c < 20 && seen == 0; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (sw_done[g]) seen = 1;
        sw_mrd[g] = DATA_W'($urandom);
        if (sw_rd[g]) begin
          n_rd++;
          last_val = sw_mrd[g];
        end
      end
      sw_req[g] = 1'b0;
      check($sformatf("sweep%0d_done", exp_ac), seen, 1);
      check($sformatf("sweep%0d_width", exp_ac), n_rd, exp_ac);
      check($sformatf("sweep%0d_rdata", exp_ac), sw_rdata[g], last_val);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
